aes_encipher_block: RTL and testbench
=====================================

Name: aes_encipher_block

Overview:
AES-128 encipher datapath that sits directly downstream of the key generator (KeyGen) and consumes its round keys. It drives the round index into KeyGen and reads the matching 128-bit round key in the same cycle. It uses a shared external 32-bit S-box (4 byte lanes) one column per cycle to perform SubBytes, then ShiftRows, MixColumns and AddRoundKey. A top-level mux grants the S-box to KeyGen while keyReady=0 and to this block otherwise.

Parameters:
NUM_ROUNDS, 10, number of cipher rounds; only 10 is legal, because KeyGen produces 11 AES-128 keys.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to encipher blockIn
keyReady  in  1  KeyGen ready; level; round keys valid while high
blockIn  in  128  plaintext, FIPS-197 column-major, bits 127:96 = column 0
round  out  4  round-key index driven to KeyGen
roundKey  in  128  KeyGen key for the current round; combinational from round
sBoxRequest  out  32  column sent to the shared S-box
sBoxResponse  in  32  S-box result, combinational, byte lane i maps to byte lane i
blockOut  out  128  ciphertext; stable while ready=1
ready  out  1  high when idle with a valid result or none pending

Behaviour:
- Reset (synchronous, highest priority, including mid-operation):
  - state=IDLE, ready=1, round=0, blockOut=0, wordCtr=0, internal state register=0.
- FSM states: IDLE, INIT, SUB, MIX, DONE.
- IDLE:
  - Accept when start&&keyReady: latch blockIn into the state register, ready<=0, round<=0, go to INIT.
  - start with keyReady=0 is ignored; no latch, no pending request.
- INIT:
  - state <= state ^ roundKey (round=0), round<=1, wordCtr<=0, go to SUB.
- SUB:
  - sBoxRequest = state column wordCtr; otherwise sBoxRequest = column 0.
  - Write sBoxResponse back into column wordCtr; wordCtr++.
  - After wordCtr==3, wordCtr wraps to 0 and go to MIX.
- MIX (one cycle):
  - Compute ShiftRows, then MixColumns (skipped when round==NUM_ROUNDS), then XOR roundKey[round].
  - If round==NUM_ROUNDS: blockOut <= result, go to DONE.
  - Otherwise: round++, go to SUB.
- DONE:
  - ready<=1, round<=0, go to IDLE.
- Latency: with start sampled at edge E0, blockOut is updated at E51 and ready rises after E52. Throughput is one block per 53 cycles minimum.
- start is ignored while ready=0; there is no queueing.
- keyReady falling mid-operation is undefined usage; the block does not check it. The bench shall not do it.
- round output is registered and glitch-free. Sequence per block: 0, 1 (x5 cycles), ..., 10 (x5 cycles), then 0.
- blockOut holds its value until the next completion or reset; it never shows partial state.
- Arithmetic:
  - GF(2^8) xtime(b) = {b[6:0],0} ^ (8'h1b & {8{b[7]}}).
  - MixColumns per column: 02·a0^03·a1^a2^a3 (rotated per row).
  - ShiftRows: row r rotates left by r columns; row r = byte r of each column word.

Decomposition:
- Shared package aes_pkg:
  - FSM state localparams.
  - NUM_ROUNDS_AES128=10.
  - xtime function.
  - shiftRows function.
- One sub-module: aes_mix_column (32-bit in/out, combinational, one column), instantiated 4×.

Test Plan:
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, blockIn 3243f6a8885a308d313198a2e0370734, start -> ready after 52 edges, blockOut 3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, blockIn 00112233445566778899aabbccddeeff -> blockOut 69c4e0d86a7b0430d8cdb78070b4c55a.
- start pulsed with keyReady=0 -> ready stays 1, round stays 0, blockOut unchanged. Then keyReady=1 and start -> normal result.
- start re-pulsed at cycles 10 and 30 during a block -> ignored; result matches a single run, and the second block starts only after ready=1.
- reset asserted at cycle 20 of a block -> next edge: ready=1, round=0, blockOut=0. A following start produces the correct ciphertext.
- Monitor round and sBoxRequest during App. B -> round shows 0 once, then each of 1..10 for exactly 5 cycles. During SUB of round 1, sBoxRequest = column words of 193de3bea0f4e22b9ac68d2ae9f84808 in order 0..3.

Source files
------------

// File: rtl/aes_encipher_block_pkg.sv
// Shared definitions for the AES-128 encipher datapath.
//   state_e           : encipher FSM states
//   NUM_ROUNDS_AES128 : round count for AES-128; KeyGen supplies 11 keys
//   xtime()           : GF(2^8) multiply by 2, reduction polynomial 0x11b
//   shift_rows()      : AES ShiftRows on a column-major 128-bit state
package aes_encipher_block_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    SUB,
    MIX,
    DONE
  } state_e;

  localparam int unsigned NUM_ROUNDS_AES128 = 10;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  // Column c occupies bits [127-32c -: 32]; row r is bits [31-8r -: 8] of a column.
  // Row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned row = 0; row < 4; row++) begin
        r[127 - 32*c - 8*row -: 8] = s[127 - 32*((c + row) % 4) - 8*row -: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_encipher_block_if.sv
// Bus between the encipher block and its neighbours (requester, KeyGen, S-box).
//   start/keyReady/blockIn : encipher request and KeyGen readiness
//   round/roundKey         : round-key index out, matching key back (combinational)
//   sBoxRequest/Response   : one column to/from the shared S-box
//   blockOut/ready         : ciphertext and idle/result-valid flag
// slave  : the encipher block
// master : the surrounding system
interface aes_encipher_block_if;
  logic         start;
  logic         keyReady;
  logic [127:0] blockIn;
  logic [3:0]   round;
  logic [127:0] roundKey;
  logic [31:0]  sBoxRequest;
  logic [31:0]  sBoxResponse;
  logic [127:0] blockOut;
  logic         ready;

  modport slave (
    input  start, keyReady, blockIn, roundKey, sBoxResponse,
    output round, sBoxRequest, blockOut, ready
  );

  modport master (
    output start, keyReady, blockIn, roundKey, sBoxResponse,
    input  round, sBoxRequest, blockOut, ready
  );
endinterface

// File: rtl/aes_mix_column.sv
// AES MixColumns for a single column (combinational).
//   col_i : input column, row 0 in bits 31:24
//   col_o : mixed column, same byte order
module aes_mix_column
  import aes_encipher_block_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a0, a1, a2, a3;

  always_comb begin
    a0 = col_i[31:24];
    a1 = col_i[23:16];
    a2 = col_i[15:8];
    a3 = col_i[7:0];
    // 03*x is expressed as xtime(x) ^ x
    col_o[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    col_o[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    col_o[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    col_o[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

endmodule

// File: rtl/aes_encipher_block.sv
// AES-128 encipher datapath fed by KeyGen round keys and a shared 32-bit S-box.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of aes_encipher_block_if (request, key, S-box, result)
// One block takes 53 cycles: INIT, then 10 x (4 SUB + 1 MIX), then DONE.
module aes_encipher_block
  import aes_encipher_block_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_AES128
) (
  input logic                 clk,
  input logic                 reset,
  aes_encipher_block_if.slave bus
);

  if (NUM_ROUNDS != NUM_ROUNDS_AES128) begin : g_bad_rounds
    $error("aes_encipher_block: NUM_ROUNDS must be 10");
  end

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_e       state_q, state_d;
  logic [127:0] data_q, data_d;
  logic [3:0]   round_q, round_d;
  logic [1:0]   word_ctr_q, word_ctr_d;
  logic [127:0] block_out_q, block_out_d;
  logic         ready_q, ready_d;

  logic [127:0] shifted;
  logic [127:0] mixed;
  logic [127:0] round_out;
  logic [31:0]  sub_col;
  logic         last_round;
  logic         accept;

  assign shifted    = shift_rows(data_q);
  assign last_round = (round_q == LAST_ROUND);
  assign accept     = bus.start && bus.keyReady;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    aes_mix_column u_mix (
      .col_i (shifted[127 - 32*c -: 32]),
      .col_o (mixed[127 - 32*c -: 32])
    );
  end

  assign round_out = (last_round ? shifted : mixed) ^ bus.roundKey;

  always_comb begin
    sub_col = data_q[127:96];
    case (word_ctr_q)
      2'd0: sub_col = data_q[127:96];
      2'd1: sub_col = data_q[95:64];
      2'd2: sub_col = data_q[63:32];
      2'd3: sub_col = data_q[31:0];
      default: sub_col = data_q[127:96];
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      data_q      <= '0;
      round_q     <= '0;
      word_ctr_q  <= '0;
      block_out_q <= '0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      round_q     <= round_d;
      word_ctr_q  <= word_ctr_d;
      block_out_q <= block_out_d;
      ready_q     <= ready_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = INIT;
      INIT:    state_d = SUB;
      SUB:     if (word_ctr_q == 2'd3) state_d = MIX;
      MIX:     state_d = last_round ? DONE : SUB;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    data_d      = data_q;
    round_d     = round_q;
    word_ctr_d  = word_ctr_q;
    block_out_d = block_out_q;
    ready_d     = ready_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = bus.blockIn;
          ready_d = 1'b0;
          round_d = '0;
        end
      end
      INIT: begin
        data_d     = data_q ^ bus.roundKey;
        round_d    = 4'd1;
        word_ctr_d = '0;
      end
      SUB: begin
        case (word_ctr_q)
          2'd0: data_d[127:96] = bus.sBoxResponse;
          2'd1: data_d[95:64]  = bus.sBoxResponse;
          2'd2: data_d[63:32]  = bus.sBoxResponse;
          2'd3: data_d[31:0]   = bus.sBoxResponse;
          default: data_d = data_q;
        endcase
        word_ctr_d = word_ctr_q + 2'd1;
      end
      MIX: begin
        data_d = round_out;
        if (last_round) begin
          block_out_d = round_out;
          // Round drops to 0 here (not only in DONE) so the final
          // round index is visible for the same 5 cycles as the others.
          round_d     = '0;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        ready_d = 1'b1;
        round_d = '0;
      end
      default: ;
    endcase
  end

  assign bus.sBoxRequest = (state_q == SUB) ? sub_col : data_q[127:96];
  assign bus.round       = round_q;
  assign bus.blockOut    = block_out_q;
  assign bus.ready       = ready_q;

endmodule

// File: tb/tb_aes_encipher_block.sv
// Self-checking bench for aes_encipher_block: models KeyGen and the S-box,
// queues expected ciphertexts at start and compares them on completion.
module tb_aes_encipher_block;

  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] ARK_B = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_encipher_block_if bus();

  aes_encipher_block #(.NUM_ROUNDS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0]   sbox [256];
  logic [127:0] rk   [11];
  logic [127:0] exp_q [$];
  logic [3:0]   round_log [0:255];
  logic [31:0]  req_log   [0:255];
  int checks = 0;
  int errors = 0;

  // KeyGen and S-box behaviour models
  always_comb bus.roundKey = (bus.round <= 4'd10) ? rk[bus.round] : '0;
  always_comb bus.sBoxResponse = {sbox[bus.sBoxRequest[31:24]], sbox[bus.sBoxRequest[23:16]],
                                  sbox[bus.sBoxRequest[15:8]],  sbox[bus.sBoxRequest[7:0]]};

  function automatic logic [7:0] tb_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = tb_xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rcon;
        rcon = tb_xtime(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic start_block(input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] ct);
    expand_key(key);
    bus.blockIn = pt;
    exp_q.push_back(ct);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Returns the number of edges after the accepting edge until ready is seen high.
  task automatic wait_done(input bit repulse, output int edges, output bit timed_out);
    edges = 0;
    timed_out = 1'b0;
    forever begin
      round_log[edges] = bus.round;
      req_log[edges]   = bus.sBoxRequest;
      if (bus.ready === 1'b1) break;
      if (edges >= 200) begin
        timed_out = 1'b1;
        break;
      end
      if (repulse && (edges == 10 || edges == 30)) begin
        bus.blockIn = ~bus.blockIn;
        bus.start   = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      edges++;
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.keyReady = 1'b0;
    bus.blockIn = '0;
    rk = '{default: '0};
    repeat (3) @(negedge clk);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
    checks++; if (bus.round !== 4'd0) begin errors++; $display("FAIL reset_round: got %0d want 0", bus.round); end
    checks++; if (bus.blockOut !== '0) begin errors++; $display("FAIL reset_blockOut: got %h want 0", bus.blockOut); end
    checks++; if (bus.sBoxRequest !== '0) begin errors++; $display("FAIL reset_sBoxRequest: got %h want 0", bus.sBoxRequest); end
    reset = 1'b0;
    bus.keyReady = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fips_b();
    int edges;
    bit to;
    logic [127:0] e;
    logic [127:0] ark;
    logic [3:0] er;
    logic [31:0] ew;
    ark = ARK_B;
    start_block(KEY_B, PT_B, CT_B);
    wait_done(1'b0, edges, to);
    checks++; if (to || edges != 52) begin errors++; $display("FAIL latency_b: got %0d edges (timeout=%0b) want 52", edges, to); end
    e = exp_q.pop_front();
    checks++; if (bus.blockOut !== e) begin errors++; $display("FAIL result_b: got %h want %h", bus.blockOut, e); end
    for (int k = 0; k <= 52; k++) begin
      er = (k >= 1 && k <= 50) ? 4'((k - 1) / 5 + 1) : 4'd0;
      checks++; if (round_log[k] !== er) begin errors++; $display("FAIL round_seq[%0d]: got %0d want %0d", k, round_log[k], er); end
    end
    for (int k = 1; k <= 4; k++) begin
      ew = ark[127 - 32*(k-1) -: 32];
      checks++; if (req_log[k] !== ew) begin errors++; $display("FAIL sbox_req_r1[%0d]: got %h want %h", k-1, req_log[k], ew); end
    end
  endtask

  task automatic test_fips_c1();
    int edges;
    bit to;
    logic [127:0] e;
    start_block(KEY_C, PT_C, CT_C);
    wait_done(1'b0, edges, to);
    checks++; if (to || edges != 52) begin errors++; $display("FAIL latency_c1: got %0d edges (timeout=%0b) want 52", edges, to); end
    e = exp_q.pop_front();
    checks++; if (bus.blockOut !== e) begin errors++; $display("FAIL result_c1: got %h want %h", bus.blockOut, e); end
  endtask

  task automatic test_no_keyready();
    int edges;
    bit to;
    logic [127:0] e;
    bus.keyReady = 1'b0;
    bus.blockIn  = PT_B;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL nokey_ready[%0d]: got %b want 1", i, bus.ready); end
      checks++; if (bus.round !== 4'd0) begin errors++; $display("FAIL nokey_round[%0d]: got %0d want 0", i, bus.round); end
      checks++; if (bus.blockOut !== CT_C) begin errors++; $display("FAIL nokey_blockOut[%0d]: got %h want %h", i, bus.blockOut, CT_C); end
      @(negedge clk);
    end
    bus.keyReady = 1'b1;
    start_block(KEY_B, PT_B, CT_B);
    wait_done(1'b0, edges, to);
    checks++; if (to || edges != 52) begin errors++; $display("FAIL latency_nokey: got %0d edges (timeout=%0b) want 52", edges, to); end
    e = exp_q.pop_front();
    checks++; if (bus.blockOut !== e) begin errors++; $display("FAIL result_nokey: got %h want %h", bus.blockOut, e); end
  endtask

  task automatic test_back_to_back();
    int edges;
    bit to;
    logic [127:0] e;
    start_block(KEY_C, PT_C, CT_C);
    wait_done(1'b1, edges, to);
    checks++; if (to || edges != 52) begin errors++; $display("FAIL latency_repulse: got %0d edges (timeout=%0b) want 52", edges, to); end
    e = exp_q.pop_front();
    checks++; if (bus.blockOut !== e) begin errors++; $display("FAIL result_repulse: got %h want %h", bus.blockOut, e); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.ready !== 1'b1 || bus.round !== 4'd0) begin
        errors++; $display("FAIL no_pending[%0d]: got ready=%b round=%0d want ready=1 round=0", i, bus.ready, bus.round);
      end
      checks++; if (bus.blockOut !== CT_C) begin errors++; $display("FAIL hold_blockOut[%0d]: got %h want %h", i, bus.blockOut, CT_C); end
    end
    start_block(KEY_B, PT_B, CT_B);
    wait_done(1'b0, edges, to);
    checks++; if (to || edges != 52) begin errors++; $display("FAIL latency_second: got %0d edges (timeout=%0b) want 52", edges, to); end
    e = exp_q.pop_front();
    checks++; if (bus.blockOut !== e) begin errors++; $display("FAIL result_second: got %h want %h", bus.blockOut, e); end
  endtask

  task automatic test_reset_mid();
    int edges;
    bit to;
    logic [127:0] e;
    start_block(KEY_B, PT_B, CT_B);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(exp_q.pop_front());
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b want 1", bus.ready); end
    checks++; if (bus.round !== 4'd0) begin errors++; $display("FAIL midreset_round: got %0d want 0", bus.round); end
    checks++; if (bus.blockOut !== '0) begin errors++; $display("FAIL midreset_blockOut: got %h want 0", bus.blockOut); end
    start_block(KEY_C, PT_C, CT_C);
    wait_done(1'b0, edges, to);
    checks++; if (to || edges != 52) begin errors++; $display("FAIL latency_after_reset: got %0d edges (timeout=%0b) want 52", edges, to); end
    e = exp_q.pop_front();
    checks++; if (bus.blockOut !== e) begin errors++; $display("FAIL result_after_reset: got %h want %h", bus.blockOut, e); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d entries want 0", exp_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    test_reset();
    test_fips_b();
    test_fips_c1();
    test_no_keyready();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
